// File: rtl/fibonacci_gen.sv
`timescale 1ns/1ps
// fibonacci_gen: iterative generator of term i of a two-seed Fibonacci sequence.
// One addition per cycle; the sticky overflow flag only covers terms up to index i.
module fibonacci_gen #(
  parameter int N_W = 5,
  parameter int D_W = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [N_W-1:0] i,
  input  logic [D_W-1:0] seed0,
  input  logic [D_W-1:0] seed1,
  output logic           ready,
  output logic           done,
  output logic [D_W-1:0] f,
  output logic           ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP   = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [D_W-1:0] t0_q, t0_d;
  logic [D_W-1:0] t1_q, t1_d;
  logic [D_W-1:0] f_q, f_d;
  logic [N_W-1:0] n_q, n_d;
  logic           ovf_acc_q, ovf_acc_d;
  logic           ovf_q, ovf_d;
  logic [D_W:0]   sum;

  // Extra top bit of the sum is the carry out of the D_W-bit addition.
  assign sum = {1'b0, t0_q} + {1'b0, t1_q};

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    n_d       = n_q;
    ovf_acc_d = ovf_acc_q;
    f_d       = f_q;
    ovf_d     = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          t0_d      = seed0;
          t1_d      = seed1;
          n_d       = i;
          ovf_acc_d = 1'b0;
          state_d   = ST_OP;
        end
      end
      ST_OP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (n_q != '0) begin
          t0_d      = t1_q;
          t1_d      = sum[D_W-1:0];
          n_d       = n_q - N_W'(1);
          // The addition made with n==1 produces term i+1, so its carry is not ours.
          ovf_acc_d = ovf_acc_q | (sum[D_W] & (n_q > N_W'(1)));
        end else begin
          f_d     = t0_q;
          ovf_d   = ovf_acc_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      t0_q      <= '0;
      t1_q      <= '0;
      n_q       <= '0;
      ovf_acc_q <= 1'b0;
      f_q       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      t0_q      <= t0_d;
      t1_q      <= t1_d;
      n_q       <= n_d;
      ovf_acc_q <= ovf_acc_d;
      f_q       <= f_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign f     = f_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_fibonacci_gen.sv
`timescale 1ns/1ps
// tb_fibonacci_gen: directed and randomized checks of fibonacci_gen against an
// exact-integer model of the seeded Fibonacci sequence.
module tb_fibonacci_gen;

  localparam int N_W = 5;
  localparam int D_W = 20;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic [N_W-1:0] i;
  logic [D_W-1:0] seed0;
  logic [D_W-1:0] seed1;
  logic           ready;
  logic           done;
  logic [D_W-1:0] f;
  logic           ovf;

  int errors = 0;
  int checks = 0;

  fibonacci_gen #(.N_W(N_W), .D_W(D_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .i     (i),
    .seed0 (seed0),
    .seed1 (seed1),
    .ready (ready),
    .done  (done),
    .f     (f),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact sequence in 64-bit integers; result and overflow follow from term idx.
  function automatic void ref_fib(input int idx, input longint unsigned s0,
                                  input longint unsigned s1,
                                  output logic [D_W-1:0] rf, output logic rovf);
    longint unsigned a, b, c;
    a = s0;
    b = s1;
    for (int k = 0; k < idx; k++) begin
      c = a + b;
      a = b;
      b = c;
    end
    rf   = D_W'(a);
    rovf = (idx >= 2) && (a >= (64'd1 << D_W));
  endfunction

  // Launches one computation and measures edges from the start-sampling edge to
  // the first cycle with done high (-1 on timeout). Returns one cycle after done.
  task automatic do_op(input int idx, input logic [D_W-1:0] s0,
                       input logic [D_W-1:0] s1, input bit poke, output int lat);
    @(negedge clk);
    start = 1'b1;
    i     = N_W'(idx);
    seed0 = s0;
    seed1 = s1;
    @(negedge clk);
    start = 1'b0;
    i     = N_W'($urandom);
    seed0 = D_W'($urandom);
    seed1 = D_W'($urandom);
    lat   = -1;
    for (int k = 1; k <= 70; k++) begin
      if (poke) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    start = poke;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    i     = '0;
    seed0 = '0;
    seed1 = '0;
    #3;
    checks++;
    if ({ready, done, ovf} !== 3'b100 || f !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b done=%b f=%0d ovf=%b, want ready=1 done=0 f=0 ovf=0",
               ready, done, f, ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    do_op(10, 20'd0, 20'd1, 1'b0, lat);
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 11", lat);
    end
    checks++;
    if (f !== 20'd55 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: f=%0d ovf=%b want f=55 ovf=0", f, ovf);
    end
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_after_done: ready=%b done=%b want 1/0", ready, done);
    end
  endtask

  task automatic test_small_index();
    int lat;
    for (int idx = 0; idx <= 1; idx++) begin
      do_op(idx, 20'd0, 20'd1, 1'b0, lat);
      checks++;
      if (lat !== idx + 1) begin
        errors++;
        $display("FAIL small_latency i=%0d: got %0d want %0d", idx, lat, idx + 1);
      end
      checks++;
      if (f !== D_W'(idx) || ovf !== 1'b0) begin
        errors++;
        $display("FAIL small_result i=%0d: f=%0d ovf=%b want f=%0d ovf=0", idx, f, ovf, idx);
      end
    end
    // Large seeds whose sum would carry: i=1 must still report no overflow.
    do_op(1, 20'hFFFFF, 20'hFFFFE, 1'b0, lat);
    checks++;
    if (f !== 20'hFFFFE || ovf !== 1'b0) begin
      errors++;
      $display("FAIL small_big_seeds: f=%0h ovf=%b want f=ffffe ovf=0", f, ovf);
    end
  endtask

  task automatic test_overflow_boundary();
    int lat;
    do_op(30, 20'd0, 20'd1, 1'b0, lat);
    checks++;
    if (lat !== 31 || f !== 20'd832040 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_i30: lat=%0d f=%0d ovf=%b want lat=31 f=832040 ovf=0", lat, f, ovf);
    end
    do_op(31, 20'd0, 20'd1, 1'b0, lat);
    checks++;
    if (lat !== 32 || f !== 20'd297693 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_i31: lat=%0d f=%0d ovf=%b want lat=32 f=297693 ovf=1", lat, f, ovf);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    do_op(10, 20'd2, 20'd1, 1'b1, lat);
    checks++;
    if (lat !== 11 || f !== 20'd123 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL lucas: lat=%0d f=%0d ovf=%b want lat=11 f=123 ovf=0", lat, f, ovf);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done_ignored: ready=%b want 1", ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL single_done cyc%0d: done=%b ready=%b want 0/1", k, done, ready);
      end
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [D_W-1:0] f_prev;
    logic           ovf_prev;
    bit             saw_done;
    do_op(31, 20'd0, 20'd1, 1'b0, lat);
    f_prev   = 20'd297693;
    ovf_prev = 1'b1;
    @(negedge clk);
    start = 1'b1;
    i     = N_W'(20);
    seed0 = 20'd0;
    seed1 = 20'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: ready=%b want 0", ready);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_to_idle: ready=%b done=%b want 1/0", ready, done);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: saw done=%b want 0", saw_done);
    end
    checks++;
    if (f !== f_prev || ovf !== ovf_prev) begin
      errors++;
      $display("FAIL abort_hold: f=%0d ovf=%b want f=%0d ovf=%b", f, ovf, f_prev, ovf_prev);
    end
    // Abort while idle must not block a following start.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    do_op(4, 20'd0, 20'd1, 1'b0, lat);
    checks++;
    if (lat !== 5 || f !== 20'd3) begin
      errors++;
      $display("FAIL abort_idle_ignored: lat=%0d f=%0d want lat=5 f=3", lat, f);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat;
    @(negedge clk);
    start = 1'b1;
    i     = N_W'(20);
    seed0 = 20'd0;
    seed1 = 20'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || f !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ready=%b done=%b f=%0d ovf=%b want 1/0/0/0", ready, done, f, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(5, 20'd0, 20'd1, 1'b0, lat);
    checks++;
    if (lat !== 6 || f !== 20'd5 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: lat=%0d f=%0d ovf=%b want lat=6 f=5 ovf=0", lat, f, ovf);
    end
  endtask

  task automatic test_random();
    int             lat, idx;
    logic [D_W-1:0] s0, s1, rf;
    logic           rovf;
    for (int n = 0; n < 25; n++) begin
      idx = int'($urandom_range(0, 31));
      if (n % 3 == 0) begin
        s0 = D_W'($urandom_range(0, 15));
        s1 = D_W'($urandom_range(0, 15));
      end else begin
        s0 = D_W'($urandom);
        s1 = D_W'($urandom);
      end
      ref_fib(idx, longint'(s0), longint'(s1), rf, rovf);
      do_op(idx, s0, s1, (n % 2) == 1, lat);
      checks++;
      if (lat !== idx + 1) begin
        errors++;
        $display("FAIL rand%0d_latency i=%0d: got %0d want %0d", n, idx, lat, idx + 1);
      end
      checks++;
      if (f !== rf || ovf !== rovf) begin
        errors++;
        $display("FAIL rand%0d_result i=%0d s0=%0d s1=%0d: f=%0d ovf=%b want f=%0d ovf=%b",
                 n, idx, s0, s1, f, ovf, rf, rovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small_index();
    test_overflow_boundary();
    test_ignore_start();
    test_abort();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fibonacci_gen.md
FIBONACCI_GEN -- requirements
Module: fibonacci_gen

Interface
REQ-001 Parameter N_W, default 5, index width in bits.
REQ-002 Parameter D_W, default 20, data/result width in bits.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request; sampled only when ready=1.
REQ-006 abort  in  1  cancels a computation in progress.
REQ-007 i  in  N_W  sequence index requested, unsigned.
REQ-008 seed0  in  D_W  term 0 of sequence, captured with start.
REQ-009 seed1  in  D_W  term 1 of sequence, captured with start.
REQ-010 ready  out  1  high in IDLE only.
REQ-011 done  out  1  single-cycle completion pulse.
REQ-012 f  out  D_W  result term i, modulo 2^D_W.
REQ-013 ovf  out  1  result overflow flag, valid with done.

Function
REQ-014 States: IDLE, OP, DONE; encoding free; no other reachable states.
REQ-015 Internal regs: t0, t1 (D_W), n (N_W), ovf_acc (1), f (D_W).
REQ-016 IDLE and start=1: t0<=seed0, t1<=seed1, n<=i, ovf_acc<=0, next OP; start=0: remain IDLE.
REQ-017 OP, abort=0, n!=0: t0<=t1, t1<=(t0+t1) mod 2^D_W, n<=n-1, remain OP.
REQ-018 OP, abort=0, n==0: f<=t0, ovf<=ovf_acc, next DONE.
REQ-019 OP, abort=1: next IDLE regardless of n; f, ovf unchanged; no done pulse.
REQ-020 ovf_acc set (sticky) when an OP addition carries out of D_W bits and n>=2 at that edge; carries with n==1 ignored (term beyond index i).
REQ-021 DONE: done=1 for exactly this cycle; next IDLE unconditionally.
REQ-022 done asserted exactly i+1 cycles after start-sampling edge; ready returns the cycle after done; total i+2 cycles start-to-ready.
REQ-023 ready and done decoded from state; never both high.
REQ-024 start while ready=0 ignored, including during DONE; i, seed0, seed1 changes after capture have no effect.
REQ-025 abort outside OP ignored; abort and n==0 same cycle -> abort wins.
REQ-026 f and ovf hold last completed result until next OP->DONE transition.
REQ-027 i=0 -> f=seed0; i=1 -> f=seed1; no addition contributes to ovf.
REQ-028 Arithmetic unsigned, wrap-around modulo 2^D_W; no saturation.

Reset
REQ-029 rst_n=0 forces IDLE immediately, regardless of clock or current state.
REQ-030 Reset values: ready=1 after async entry to IDLE, done=0, f=0, ovf=0, t0=t1=0, n=0, ovf_acc=0.
REQ-031 Reset mid-OP discards computation; no done pulse; first start after rst_n rises accepted normally.

Verification
REQ-032 Defaults, seeds 0/1, i=10 -> done 11 cycles after start edge, f=55, ovf=0, ready next cycle.
REQ-033 Seeds 0/1, i=0 then i=1 -> f=0 after 1 cycle, then f=1 after 2 cycles, ovf=0 both.
REQ-034 Seeds 0/1, i=30 -> f=832040, ovf=0 (F(31) carry ignored); i=31 -> f=297693, ovf=1.
REQ-035 Seeds 2/1 (Lucas), i=10 -> f=123; start pulsed during OP and DONE -> ignored, single done.
REQ-036 i=20, abort asserted 5 cycles after start -> IDLE next cycle, no done, f/ovf retain prior values.
REQ-037 i=20, rst_n low mid-OP between clock edges -> ready=1, f=0, ovf=0 immediately; following start i=5 -> f=5.
